hi_sim_multimode: RTL and testbench

HI_SIM_MULTIMODE -- requirements
Module: hi_sim_multimode

---
 rtl/hi_sim_pkg.sv | 35 +++
 rtl/hi_sim_multimode_if.sv | 32 +++
 rtl/hi_sim_hyst.sv | 31 +++
 rtl/hi_sim_multimode.sv | 123 ++++++++++++
 tb/tb_hi_sim_multimode.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hi_sim_pkg.sv
// Shared definitions for the hi_sim multimode tag simulator:
// mode encodings and the per-mode coil drive decode.
package hi_sim_pkg;

   typedef enum logic [2:0] {
      MODE_OFF     = 3'b000,
      MODE_LISTEN  = 3'b001,
      MODE_DIRECT  = 3'b010,
      MODE_OOK     = 3'b011,
      MODE_BPSK    = 3'b100,
      MODE_SHALLOW = 3'b101,
      MODE_RSVD6   = 3'b110,
      MODE_RSVD7   = 3'b111
   } mode_e;

   typedef struct packed {
      logic oe1;
      logic oe4;
   } drive_t;

   // Reserved encodings fall through to the all-off default.
   function automatic drive_t mode_drive(input mode_e mode, input logic mod_bit, input logic sc);
      drive_t d;
      d = '0;
      case (mode)
         MODE_DIRECT:  d.oe1 = mod_bit;
         MODE_OOK:     d.oe1 = mod_bit & sc;
         MODE_BPSK:    d.oe1 = sc ^ mod_bit;
         MODE_SHALLOW: d.oe4 = mod_bit & sc;
         default:      d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/hi_sim_multimode_if.sv
// Signal bundle between the ARM/ADC side and the hi_sim core. There is no
// valid/ready handshake: inputs are sampled on ck_1356meg at fixed counter phases.
interface hi_sim_multimode_if #(
   parameter int ADC_WIDTH = 8
);
   logic [ADC_WIDTH-1:0] adc_d;
   logic [2:0]           mod_type;
   logic                 ssp_dout;
   logic                 adc_clk;
   logic                 ssp_clk;
   logic                 ssp_frame;
   logic                 ssp_din;
   logic                 pwr_lo;
   logic                 pwr_hi;
   logic                 pwr_oe1;
   logic                 pwr_oe2;
   logic                 pwr_oe3;
   logic                 pwr_oe4;
   logic                 dbg;

   modport master (
      output adc_d, mod_type, ssp_dout,
      input  adc_clk, ssp_clk, ssp_frame, ssp_din,
      input  pwr_lo, pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4, dbg
   );

   modport slave (
      input  adc_d, mod_type, ssp_dout,
      output adc_clk, ssp_clk, ssp_frame, ssp_din,
      output pwr_lo, pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4, dbg
   );
endinterface

// File: rtl/hi_sim_hyst.sv
// Field-detect comparator with hysteresis; updates only on sample strobes.
module hi_sim_hyst #(
   parameter int ADC_WIDTH = 8,
   parameter int HYST_LO   = 5,
   parameter int HYST_HI   = 200
) (
   input  logic                 ck_1356meg,
   input  logic                 rst_n,
   input  logic                 i_sample,
   input  logic [ADC_WIDTH-1:0] i_adc_d,
   output logic                 o_field
);
   localparam logic [ADC_WIDTH-1:0] LP_LO = ADC_WIDTH'(HYST_LO);
   localparam logic [ADC_WIDTH-1:0] LP_HI = ADC_WIDTH'(HYST_HI);

   logic r_field;

   always_ff @(posedge ck_1356meg) begin
      if (!rst_n) begin
         r_field <= 1'b0;
      end else if (i_sample) begin
         if (i_adc_d >= LP_HI) begin
            r_field <= 1'b1;
         end else if (i_adc_d <= LP_LO) begin
            r_field <= 1'b0;
         end
      end
   end

   assign o_field = r_field;
endmodule

// File: rtl/hi_sim_multimode.sv
// hi_sim multimode core: ADC clocking, SSP framing to the ARM and coil drive.
// Define HI_SIM_DEBUG_EN to route the field bit onto dbg.
module hi_sim_multimode
   import hi_sim_pkg::*;
#(
   parameter int ADC_WIDTH = 8,
   parameter int HYST_LO   = 5,
   parameter int HYST_HI   = 200,
   parameter int SSP_DIV   = 32,
   parameter int SUB_DIV   = 16
) (
   input  logic                ck_1356meg,
   input  logic                rst_n,
   hi_sim_multimode_if.slave   bus
);
   localparam int SSP_W = $clog2(SSP_DIV);
   localparam int SUB_W = $clog2(SUB_DIV);
   localparam logic [SSP_W-1:0] SSP_LAST = SSP_W'(SSP_DIV - 1);
   localparam logic [SSP_W-1:0] SSP_HALF = SSP_W'(SSP_DIV / 2);
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);
   localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(SUB_DIV / 2);

   logic [SSP_W-1:0] r_ssp_cnt;
   logic [2:0]       r_bit_cnt;
   logic [SUB_W-1:0] r_sub_cnt;
   logic r_adc_clk, r_ssp_clk, r_ssp_frame, r_ssp_din, r_mod_bit, r_oe1, r_oe4;
   mode_e r_mode, w_mode_next;
   logic w_field, w_ssp_zero, w_ssp_wrap, w_frame_start, w_sc, w_sub_restart;
   drive_t w_drive;

   assign w_ssp_zero    = (r_ssp_cnt == '0);
   assign w_ssp_wrap    = (r_ssp_cnt == SSP_LAST);
   assign w_frame_start = w_ssp_zero && (r_bit_cnt == 3'd0);
   assign w_sc          = (r_sub_cnt >= SUB_HALF);

   // Sample in the cycle where adc_clk falls, i.e. while it is currently high.
   hi_sim_hyst #(
      .ADC_WIDTH (ADC_WIDTH),
      .HYST_LO   (HYST_LO),
      .HYST_HI   (HYST_HI)
   ) u_hyst (
      .ck_1356meg (ck_1356meg),
      .rst_n      (rst_n),
      .i_sample   (r_adc_clk),
      .i_adc_d    (bus.adc_d),
      .o_field    (w_field)
   );

   always_ff @(posedge ck_1356meg) begin
      if (!rst_n) begin
         r_mode <= MODE_OFF;
      end else begin
         r_mode <= w_mode_next;
      end
   end

   // Mode is only adopted at a frame boundary; a new mode restarts the subcarrier.
   always_comb begin
      w_mode_next   = r_mode;
      w_sub_restart = 1'b0;
      if (w_frame_start) begin
         w_mode_next   = mode_e'(bus.mod_type);
         w_sub_restart = (w_mode_next != r_mode);
      end
   end

   assign w_drive = mode_drive(r_mode, r_mod_bit, w_sc);

   // SSP outputs are registered decodes of the counters and so trail them by one cycle.
   always_ff @(posedge ck_1356meg) begin
      if (!rst_n) begin
         r_adc_clk   <= 1'b0;
         r_ssp_cnt   <= '0;
         r_bit_cnt   <= 3'd0;
         r_sub_cnt   <= '0;
         r_ssp_clk   <= 1'b0;
         r_ssp_frame <= 1'b0;
         r_ssp_din   <= 1'b0;
         r_mod_bit   <= 1'b0;
         r_oe1       <= 1'b0;
         r_oe4       <= 1'b0;
      end else begin
         r_adc_clk   <= ~r_adc_clk;
         r_ssp_cnt   <= w_ssp_wrap ? '0 : r_ssp_cnt + 1'b1;
         if (w_ssp_wrap) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
         r_ssp_clk   <= (r_ssp_cnt >= SSP_HALF);
         r_ssp_frame <= (r_bit_cnt == 3'd0);
         if (w_ssp_zero) begin
            r_ssp_din <= w_field;
         end
         if (r_ssp_cnt == SSP_HALF) begin
            r_mod_bit <= bus.ssp_dout;
         end
         if (w_sub_restart || (r_sub_cnt == SUB_LAST)) begin
            r_sub_cnt <= '0;
         end else begin
            r_sub_cnt <= r_sub_cnt + 1'b1;
         end
         r_oe1 <= w_drive.oe1;
         r_oe4 <= w_drive.oe4;
      end
   end

   assign bus.adc_clk   = r_adc_clk;
   assign bus.ssp_clk   = r_ssp_clk;
   assign bus.ssp_frame = r_ssp_frame;
   assign bus.ssp_din   = r_ssp_din;
   assign bus.pwr_lo    = 1'b0;
   assign bus.pwr_hi    = 1'b0;
   assign bus.pwr_oe1   = r_oe1;
   assign bus.pwr_oe2   = 1'b0;
   assign bus.pwr_oe3   = 1'b0;
   assign bus.pwr_oe4   = r_oe4;

`ifdef HI_SIM_DEBUG_EN
   assign bus.dbg = w_field;
`else
   assign bus.dbg = 1'b0;
`endif

endmodule

// File: tb/tb_hi_sim_multimode.sv
// Directed bench for hi_sim_multimode: cycle model of all outputs plus
// targeted checks of framing, hysteresis, modes and mid-frame reset.
`timescale 1ns/1ps
module tb_hi_sim_multimode;
   localparam int W  = 8;
   localparam int LO = 5;
   localparam int HI = 200;
   localparam int D  = 32;
   localparam int S  = 16;

   // ---------------- clock / reset ----------------
   logic ck_1356meg = 1'b0;
   logic rst_n;
   always #5 ck_1356meg = ~ck_1356meg;

   hi_sim_multimode_if #(.ADC_WIDTH(W)) bus ();

   hi_sim_multimode #(
      .ADC_WIDTH (W),
      .HYST_LO   (LO),
      .HYST_HI   (HI),
      .SSP_DIV   (D),
      .SUB_DIV   (S)
   ) dut (
      .ck_1356meg (ck_1356meg),
      .rst_n      (rst_n),
      .bus        (bus)
   );

   logic [10:0] obs;
   assign obs = {bus.adc_clk, bus.ssp_clk, bus.ssp_frame, bus.ssp_din, bus.pwr_lo, bus.pwr_hi,
                 bus.pwr_oe1, bus.pwr_oe2, bus.pwr_oe3, bus.pwr_oe4, bus.dbg};

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [0:0] exp_q[$];

   int   adc_tab [10] = '{0, 100, 210, 100, 4, 100, 200, 6, 5, 199};
   logic fld_tab [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

   // reference model state; k is the index of the last edge since reset release
   int k;
   int m_sub;
   logic m_adc_clk, m_field, m_din, m_modbit, m_oe1, m_oe4;
   logic [2:0] m_mode;

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_checks++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h (edge %0d)", tag, o, e, k);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      logic [10:0] e;
      int cnt_pre, bit_pre;
      logic sc_pre, fld_pre, dbg_e;
      @(posedge ck_1356meg);
      if (!rst_n) begin
         k = -1; m_sub = 0; m_mode = 3'b000;
         m_adc_clk = 1'b0; m_field = 1'b0; m_din = 1'b0; m_modbit = 1'b0; m_oe1 = 1'b0; m_oe4 = 1'b0;
         e = '0;
      end else begin
         k++;
         cnt_pre = k % D;
         bit_pre = (k / D) % 8;
         sc_pre  = (m_sub >= S / 2);
         fld_pre = m_field;
         m_oe1 = 1'b0;
         m_oe4 = 1'b0;
         case (m_mode)
            3'b010:  m_oe1 = m_modbit;
            3'b011:  m_oe1 = m_modbit & sc_pre;
            3'b100:  m_oe1 = sc_pre ^ m_modbit;
            3'b101:  m_oe4 = m_modbit & sc_pre;
            default: m_oe1 = 1'b0;
         endcase
         if (m_adc_clk) begin
            if (int'(bus.adc_d) >= HI) m_field = 1'b1;
            else if (int'(bus.adc_d) <= LO) m_field = 1'b0;
         end
         m_adc_clk = ~m_adc_clk;
         if (cnt_pre == 0) m_din = fld_pre;
         if (cnt_pre == D / 2) m_modbit = bus.ssp_dout;
         if (cnt_pre == 0 && bit_pre == 0) begin
            m_sub  = (bus.mod_type != m_mode) ? 0 : (m_sub + 1) % S;
            m_mode = bus.mod_type;
         end else begin
            m_sub = (m_sub + 1) % S;
         end
`ifdef HI_SIM_DEBUG_EN
         dbg_e = m_field;
`else
         dbg_e = 1'b0;
`endif
         e = {m_adc_clk, (cnt_pre >= D / 2), (bit_pre == 0), m_din, 1'b0, 1'b0,
              m_oe1, 1'b0, 1'b0, m_oe4, dbg_e};
      end
      #1;
      check("outputs", 32'(obs), 32'(e));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic step_until(input int m, input int r);
      for (int i = 0; i < 2 * m && (k % m) != r; i++) step();
   endtask

   // ---------------- directed sequence ----------------
   int frame_hi, frame_rise, clk_hi, clk_rise, toggles, last_chg, hi_cnt;
   logic prev_f, prev_c, prev_o;

   initial begin
      rst_n = 1'b0;
      bus.adc_d = '0;
      bus.mod_type = 3'b000;
      bus.ssp_dout = 1'b0;
      k = -1;
      run(3);
      check("reset_outputs", 32'(obs), 32'd0);

      // free run: one frame pulse, eight 50% ssp_clk periods
      bus.mod_type = 3'b001;
      rst_n = 1'b1;
      frame_hi = 0; frame_rise = 0; clk_hi = 0; clk_rise = 0; prev_f = 1'b0; prev_c = 1'b0;
      for (int i = 0; i < 8 * D; i++) begin
         bus.ssp_dout = 1'($urandom_range(0, 1));
         step();
         frame_hi += int'(bus.ssp_frame);
         clk_hi   += int'(bus.ssp_clk);
         if (bus.ssp_frame && !prev_f) frame_rise++;
         if (bus.ssp_clk && !prev_c) clk_rise++;
         prev_f = bus.ssp_frame;
         prev_c = bus.ssp_clk;
      end
      check("frame_cycles", frame_hi, D);
      check("frame_pulses", frame_rise, 1);
      check("sspclk_periods", clk_rise, 8);
      check("sspclk_high", clk_hi, 4 * D);

      // hysteresis sequence, field bit observed through ssp_din
      for (int i = 0; i < 10; i++) begin
         step_until(D, 0);
         bus.adc_d = W'(adc_tab[i]);
         exp_q.push_back(fld_tab[i]);
         run(D);
         check("ssp_din_hyst", bus.ssp_din, exp_q.pop_front());
      end

      // a high value present only while adc_clk rises must be ignored
      step();
      bus.adc_d = W'(210);
      exp_q.push_back(1'b0);
      step();
      bus.adc_d = W'(100);
      step_until(D, 0);
      check("no_sample_rise", bus.ssp_din, exp_q.pop_front());
      bus.adc_d = W'(210);
      exp_q.push_back(1'b1);
      step();
      bus.adc_d = W'(100);
      step_until(D, 0);
      check("sample_fall", bus.ssp_din, exp_q.pop_front());

      // OOK from release: subcarrier restarts as mode leaves OFF
      rst_n = 1'b0;
      bus.mod_type = 3'b011;
      bus.ssp_dout = 1'b1;
      run(2);
      rst_n = 1'b1;
      run(D);
      toggles = 0; last_chg = -1; prev_o = bus.pwr_oe1;
      for (int i = 0; i < 8 * S; i++) begin
         step();
         if (k == 40) check("ook_phase", bus.pwr_oe1, 1'b0);
         if (bus.pwr_oe1 != prev_o) begin
            toggles++;
            if (last_chg >= 0) check("ook_half_period", k - last_chg, S / 2);
            last_chg = k;
         end
         prev_o = bus.pwr_oe1;
      end
      check("ook_toggles", toggles, 16);
      bus.ssp_dout = 1'b0;
      run(D + 2);
      hi_cnt = 0;
      for (int i = 0; i < 4 * S; i++) begin
         step();
         hi_cnt += int'(bus.pwr_oe1);
      end
      check("ook_data0", hi_cnt, 0);

      // OOK -> BPSK mid-frame: held until the frame boundary
      bus.ssp_dout = 1'b1;
      step_until(8 * D, 3 * D);
      bus.mod_type = 3'b100;
      step_until(8 * D, 8 * D - 1);
      check("mode_held", bus.pwr_oe1, 1'b1);
      run(2);
      check("bpsk_sc_low", bus.pwr_oe1, 1'b1);
      run(8);
      check("bpsk_sc_high", bus.pwr_oe1, 1'b0);

      // SHALLOW drives oe4 only
      bus.mod_type = 3'b101;
      step_until(8 * D, 0);
      hi_cnt = 0; toggles = 0;
      for (int i = 0; i < 4 * S; i++) begin
         step();
         hi_cnt  += int'(bus.pwr_oe4);
         toggles += int'(bus.pwr_oe1);
      end
      check("shallow_oe4_high", hi_cnt, 2 * S);
      check("shallow_oe1_zero", toggles, 0);

      // reserved encoding behaves as OFF
      bus.mod_type = 3'b111;
      step_until(8 * D, 0);
      hi_cnt = 0;
      for (int i = 0; i < 4 * S; i++) begin
         step();
         hi_cnt += int'(bus.pwr_oe1) + int'(bus.pwr_oe4);
      end
      check("reserved_off", hi_cnt, 0);

      // DIRECT follows mod_bit
      bus.mod_type = 3'b010;
      step_until(8 * D, 0);
      run(2 * D);
      check("direct_one", bus.pwr_oe1, 1'b1);
      bus.ssp_dout = 1'b0;
      run(2 * D);
      check("direct_zero", bus.pwr_oe1, 1'b0);
      for (int i = 0; i < 2 * D; i++) begin
         bus.ssp_dout = 1'($urandom_range(0, 1));
         step();
      end

      // one-cycle reset at bit 5 aborts the frame
      step_until(8 * D, 5 * D + 3);
      rst_n = 1'b0;
      step();
      check("midframe_reset", 32'(obs), 32'd0);
      rst_n = 1'b1;
      step();
      check("restart_frame", bus.ssp_frame, 1'b1);
      check("restart_sspclk", bus.ssp_clk, 1'b0);
      check("restart_adcclk", bus.adc_clk, 1'b1);
      run(8 * D);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
